// File: rtl/task1_rom.sv
// task1_rom: constant Task 1 program image, DEPTH x WIDTH words; TASK1_ROM_UNMAPPED_FLAG_EN adds an out-of-image flag.
// Latency: one clock, with read_data registered and reset forcing the register to zero.
// Backpressure: none; a new address is accepted on every rising edge.
module task1_rom #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] address,
    output logic [WIDTH-1:0]         read_data
`ifdef TASK1_ROM_UNMAPPED_FLAG_EN
    ,
    output logic                     unmapped
`endif
);

    localparam int AW         = $clog2(DEPTH);
    localparam int IMAGE_LAST = 5;

    // Every address outside the program image decodes to zero, so no entry is ever X.
    function automatic logic [WIDTH-1:0] image_word(input logic [AW-1:0] a);
        logic [WIDTH-1:0] w;
        w = '0;
        case (a)
            AW'(1):  w = WIDTH'(10'b1100110100);
            AW'(2):  w = WIDTH'(10'b1100111101);
            AW'(3):  w = WIDTH'(10'b0100110110);
            AW'(4):  w = WIDTH'(10'b1111100101);
            AW'(5):  w = WIDTH'(10'b0010000010);
            default: w = '0;
        endcase
        return w;
    endfunction

    // Initialised so the output reads zero before the first edge.
    logic [WIDTH-1:0] data_q = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= image_word(address);
        end
    end

    assign read_data = data_q;

`ifdef TASK1_ROM_UNMAPPED_FLAG_EN
    logic unmapped_q = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            unmapped_q <= 1'b0;
        end else begin
            unmapped_q <= (address > AW'(IMAGE_LAST));
        end
    end

    assign unmapped = unmapped_q;
`endif

endmodule

// File: tb/tb_task1_rom.sv
// Bench for task1_rom: array-based reference model checked every negedge, plus literal expectations.
module tb_task1_rom;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] address;
    logic [9:0] read_data;
`ifdef TASK1_ROM_UNMAPPED_FLAG_EN
    logic       unmapped;
`endif

    int vectors    = 0;
    int miscompares = 0;

    task1_rom #(.DEPTH(1024), .WIDTH(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read_data (read_data)
`ifdef TASK1_ROM_UNMAPPED_FLAG_EN
        ,
        .unmapped  (unmapped)
`endif
    );

    always #5 clk = ~clk;

    // Reference: full 1024-word memory image, one-edge delayed lookup.
    logic [9:0] img [1024];
    logic [9:0] model_rd = '0;
    logic       model_um = 1'b0;

    initial begin
        for (int i = 0; i < 1024; i++) img[i] = '0;
        img[1] = 10'b1100110100;
        img[2] = 10'b1100111101;
        img[3] = 10'b0100110110;
        img[4] = 10'b1111100101;
        img[5] = 10'b0010000010;
    end

    always @(posedge clk) begin
        if (reset) begin
            model_rd = '0;
            model_um = 1'b0;
        end else begin
            model_rd = img[address];
            model_um = (int'(address) >= 6);
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (read_data !== model_rd) begin
            miscompares++;
            $display("FAIL model_rd t=%0t got=%b expected=%b", $time, read_data, model_rd);
        end
`ifdef TASK1_ROM_UNMAPPED_FLAG_EN
        vectors++;
        if (unmapped !== model_um) begin
            miscompares++;
            $display("FAIL model_um t=%0t got=%b expected=%b", $time, unmapped, model_um);
        end
`endif
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_um(input string name, input logic exp);
`ifdef TASK1_ROM_UNMAPPED_FLAG_EN
        vectors++;
        if (unmapped !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b expected=%b", name, unmapped, exp);
        end
`else
        if (exp === 1'bx) $display("unused %s", name);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] step_exp [6];

    initial begin
        step_exp[0] = 10'b0000000000;
        step_exp[1] = 10'b1100110100;
        step_exp[2] = 10'b1100111101;
        step_exp[3] = 10'b0100110110;
        step_exp[4] = 10'b1111100101;
        step_exp[5] = 10'b0010000010;

        reset   = 1'b1;
        address = 10'd1;
        #1;
        check("pre_edge", read_data, 10'b0);

        // Reset held two edges with address=1.
        tick(); check("rst_edge1", read_data, 10'b0);
        tick(); check("rst_edge2", read_data, 10'b0);
        check_um("rst_um", 1'b0);
        reset = 1'b0;
        tick(); check("first_read", read_data, 10'b1100110100);

        // Sequential program fetch.
        for (int a = 0; a < 6; a++) begin
            address = 10'(a);
            tick();
            check($sformatf("step%0d", a), read_data, step_exp[a]);
            check_um($sformatf("step_um%0d", a), 1'b0);
        end

        // Address changes between edges take effect only at the next edge.
        address = 10'd1;
        tick(); check("mid_before", read_data, 10'b1100110100);
        #2 address = 10'd2;
        #1 check("mid_hold", read_data, 10'b1100110100);
        tick(); check("mid_after", read_data, 10'b1100111101);

        // Outside the image.
        address = 10'd1023;
        tick(); check("addr1023", read_data, 10'b0);
        check_um("um1023", 1'b1);
        address = 10'd6;
        tick(); check("addr6", read_data, 10'b0);
        check_um("um6", 1'b1);
        address = 10'd5;
        tick(); check("addr5", read_data, 10'b0010000010);
        check_um("um5", 1'b0);

        // Reset pulse in the middle of steady fetches.
        address = 10'd2;
        tick(); check("pulse_pre", read_data, 10'b1100111101);
        reset = 1'b1;
        tick(); check("pulse_rst", read_data, 10'b0);
        check_um("pulse_um", 1'b0);
        reset = 1'b0;
        tick(); check("pulse_post", read_data, 10'b1100111101);

        // Scattered addresses, including aliases of image addresses, checked by the model.
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0:       address = 10'($urandom_range(0, 7));
                1:       address = 10'($urandom_range(0, 5) + 512);
                2:       address = 10'($urandom_range(0, 5) + 1024 - 8);
                default: address = 10'($urandom_range(0, 1023));
            endcase
            reset = (i == 20);
            tick();
        end
        reset = 1'b0;
        tick();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
